// File: rtl/key_event_scheduler.sv
// Merges SPI and button key bytes into one FIFO and releases them to calc_display only during vblank.
// Optional KEY_FILTER_EN: discard bytes that are not calculator keys before they reach the hold registers.
module key_event_scheduler #(
  parameter int FIFO_DEPTH    = 8,
  parameter int MAX_PER_FRAME = 1,
  parameter int MIN_GAP       = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          spi_valid,
  input  logic [7:0]                    spi_data,
  input  logic                          btn_valid,
  input  logic [7:0]                    btn_data,
  input  logic                          vblank,
  output logic [7:0]                    key_ascii,
  output logic                          key_pressed,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [7:0]                    drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(MAX_PER_FRAME + 1);
  localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  // state | meaning
  // IDLE  | outside vblank, nothing issued
  // ARMED | in vblank, may pop one key per cycle
  // GAP   | enforcing MIN_GAP idle cycles after a pop
  // DONE  | frame quota used, wait for vblank to end
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_GAP, S_DONE} state_t;

  logic          spi_take, btn_take;

`ifdef KEY_FILTER_EN
  function automatic logic key_ok(input logic [7:0] b);
    key_ok = ((b >= 8'h30) && (b <= 8'h39)) ||
             (b inside {8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h3D, 8'h2E, 8'h43, 8'h08, 8'h0D});
  endfunction
  assign spi_take = spi_valid & key_ok(spi_data);
  assign btn_take = btn_valid & key_ok(btn_data);
`else
  assign spi_take = spi_valid;
  assign btn_take = btn_valid;
`endif

  logic          spi_full_q, spi_full_d, btn_full_q, btn_full_d;
  logic [7:0]    spi_hold_q, spi_hold_d, btn_hold_q, btn_hold_d;
  logic          rr_btn_q, rr_btn_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_q, drop_d;
  state_t        state_q, state_d;
  logic [IW-1:0] issued_q, issued_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    key_ascii_q, key_ascii_d;
  logic          key_pressed_q, key_pressed_d;

  logic          fifo_full, grant_spi, grant_btn, push, pop;
  logic          spi_drop, btn_drop;
  logic [7:0]    push_data;
  logic [1:0]    n_drops;
  logic [8:0]    drop_sum;

  always_comb begin
    fifo_full = (count_q == (AW+1)'(FIFO_DEPTH));
    grant_spi = !fifo_full && spi_full_q && (!btn_full_q || !rr_btn_q);
    grant_btn = !fifo_full && btn_full_q && (!spi_full_q || rr_btn_q);
    push      = grant_spi | grant_btn;
    push_data = grant_spi ? spi_hold_q : btn_hold_q;

    // A full hold that is being drained this cycle can accept a new byte.
    spi_drop  = spi_take && spi_full_q && !grant_spi;
    btn_drop  = btn_take && btn_full_q && !grant_btn;

    spi_full_d = spi_full_q;
    spi_hold_d = spi_hold_q;
    if (grant_spi) spi_full_d = 1'b0;
    if (spi_take && !spi_drop) begin
      spi_full_d = 1'b1;
      spi_hold_d = spi_data;
    end

    btn_full_d = btn_full_q;
    btn_hold_d = btn_hold_q;
    if (grant_btn) btn_full_d = 1'b0;
    if (btn_take && !btn_drop) begin
      btn_full_d = 1'b1;
      btn_hold_d = btn_data;
    end

    rr_btn_d = rr_btn_q;
    if (grant_spi) rr_btn_d = 1'b1;
    if (grant_btn) rr_btn_d = 1'b0;

    overflow_d = overflow_q | spi_drop | btn_drop;
    n_drops    = {1'b0, spi_drop} + {1'b0, btn_drop};
    drop_sum   = {1'b0, drop_q} + {7'b0, n_drops};
    drop_d     = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_comb begin
    state_d       = state_q;
    issued_d      = issued_q;
    gap_d         = gap_q;
    key_ascii_d   = key_ascii_q;
    key_pressed_d = 1'b0;
    pop           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (vblank) begin
          state_d  = S_ARMED;
          issued_d = '0;
        end
      end
      S_ARMED: begin
        if (!vblank) begin
          state_d = S_IDLE;
        end else if (issued_q == IW'(MAX_PER_FRAME)) begin
          state_d = S_DONE;
        end else if (count_q != '0) begin
          pop           = 1'b1;
          key_ascii_d   = mem_q[rd_ptr_q];
          key_pressed_d = 1'b1;
          issued_d      = issued_q + IW'(1);
          if (MIN_GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GW'(MIN_GAP);
          end
        end
      end
      S_GAP: begin
        if (!vblank) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
          if (gap_q <= GW'(1)) state_d = S_ARMED;
        end
      end
      S_DONE: begin
        if (!vblank) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + (AW+1)'(1);
    if (!push && pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spi_full_q    <= 1'b0;
      spi_hold_q    <= '0;
      btn_full_q    <= 1'b0;
      btn_hold_q    <= '0;
      rr_btn_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      drop_q        <= '0;
      state_q       <= S_IDLE;
      issued_q      <= '0;
      gap_q         <= '0;
      key_ascii_q   <= '0;
      key_pressed_q <= 1'b0;
    end else begin
      spi_full_q    <= spi_full_d;
      spi_hold_q    <= spi_hold_d;
      btn_full_q    <= btn_full_d;
      btn_hold_q    <= btn_hold_d;
      rr_btn_q      <= rr_btn_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      drop_q        <= drop_d;
      state_q       <= state_d;
      issued_q      <= issued_d;
      gap_q         <= gap_d;
      key_ascii_q   <= key_ascii_d;
      key_pressed_q <= key_pressed_d;
    end
  end

  assign key_ascii   = key_ascii_q;
  assign key_pressed = key_pressed_q;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Scoreboard bench: expected key bytes are queued at stimulus time, a negedge monitor checks each issue.
// Two instances share stimulus: default limits (one key per frame) and MAX_PER_FRAME=4 for gap spacing.
module tb_key_event_scheduler;
  localparam int MIN_GAP = 2;

  logic       clk = 1'b0, rst = 1'b1;
  logic       spi_valid = 1'b0, btn_valid = 1'b0, vblank = 1'b0;
  logic [7:0] spi_data = '0, btn_data = '0;

  logic [7:0] ka1, ka4, dc1, dc4;
  logic       kp1, kp4, ov1, ov4;
  logic [3:0] fc1, fc4;

  key_event_scheduler u_dut1 (
    .clk(clk), .reset(rst), .spi_valid(spi_valid), .spi_data(spi_data),
    .btn_valid(btn_valid), .btn_data(btn_data), .vblank(vblank),
    .key_ascii(ka1), .key_pressed(kp1), .fifo_count(fc1), .overflow(ov1), .drop_count(dc1));

  key_event_scheduler #(.FIFO_DEPTH(8), .MAX_PER_FRAME(4), .MIN_GAP(MIN_GAP)) u_dut4 (
    .clk(clk), .reset(rst), .spi_valid(spi_valid), .spi_data(spi_data),
    .btn_valid(btn_valid), .btn_data(btn_data), .vblank(vblank),
    .key_ascii(ka4), .key_pressed(kp4), .fifo_count(fc4), .overflow(ov4), .drop_count(dc4));

  always #5 clk = ~clk;

  int         n_vec = 0, n_err = 0;
  logic [7:0] exp1[$], exp4[$];
  int         p1 = 0, p4 = 0, cyc = 0, last1 = -1, last4 = -1;
  logic [7:0] e;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      last1 = -1;
      last4 = -1;
    end else begin
      if (kp1) begin
        p1++;
        n_vec++;
        if (exp1.size() == 0) begin
          n_err++;
          $display("FAIL issue1 unexpected key 0x%02h, queue empty", ka1);
        end else begin
          e = exp1.pop_front();
          if (ka1 !== e) begin
            n_err++;
            $display("FAIL issue1 key got 0x%02h want 0x%02h", ka1, e);
          end
        end
        if (last1 >= 0) begin
          n_vec++;
          if (cyc - last1 - 1 < MIN_GAP) begin
            n_err++;
            $display("FAIL gap1 idle cycles got %0d want >= %0d", cyc - last1 - 1, MIN_GAP);
          end
        end
        last1 = cyc;
      end
      if (kp4) begin
        p4++;
        n_vec++;
        if (exp4.size() == 0) begin
          n_err++;
          $display("FAIL issue4 unexpected key 0x%02h, queue empty", ka4);
        end else begin
          e = exp4.pop_front();
          if (ka4 !== e) begin
            n_err++;
            $display("FAIL issue4 key got 0x%02h want 0x%02h", ka4, e);
          end
        end
        if (last4 >= 0) begin
          n_vec++;
          if (cyc - last4 - 1 < MIN_GAP) begin
            n_err++;
            $display("FAIL gap4 idle cycles got %0d want >= %0d", cyc - last4 - 1, MIN_GAP);
          end
        end
        last4 = cyc;
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [7:0] b);
    exp1.push_back(b);
    exp4.push_back(b);
  endtask

  task automatic strobe_spi(input logic [7:0] d);
    spi_valid = 1'b1;
    spi_data  = d;
    tick(1);
    spi_valid = 1'b0;
  endtask

  task automatic strobe_both(input logic [7:0] a, input logic [7:0] b);
    spi_valid = 1'b1;
    spi_data  = a;
    btn_valid = 1'b1;
    btn_data  = b;
    tick(1);
    spi_valid = 1'b0;
    btn_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp1.delete();
    exp4.delete();
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic window(input int hi, input int lo);
    vblank = 1'b1;
    tick(hi);
    vblank = 1'b0;
    tick(lo);
  endtask

  int found;

  initial begin
    tick(3);
    chk("rst_key_pressed", kp1, 0);
    chk("rst_fifo_count", fc1, 0);
    chk("rst_overflow", ov1, 0);
    chk("rst_drop_count", dc1, 0);
    chk("rst_key_ascii", ka1, 0);
    rst = 1'b0;
    tick(2);

    // single key: visible in FIFO one edge after the hold loads
    push_exp(8'h35);
    strobe_spi(8'h35);
    chk("t1_count_at_hold", fc1, 0);
    tick(1);
    chk("t1_count_after_write", fc1, 1);
    p1 = 0;
    window(10, 3);
    chk("t1_pulses", p1, 1);
    chk("t1_count_drained", fc1, 0);

    // simultaneous sources, round robin starting at SPI
    do_reset();
    push_exp(8'h31); push_exp(8'h32);
    strobe_both(8'h31, 8'h32);
    tick(3);
    push_exp(8'h33); push_exp(8'h34);
    strobe_both(8'h33, 8'h34);
    tick(3);
    chk("t2_count", fc1, 4);
    p1 = 0;
    repeat (4) window(10, 3);
    chk("t2_pulses", p1, 4);
    chk("t2_count_drained", fc1, 0);

    // one key per vblank window
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_exp(8'h36 + 8'(i));
      strobe_spi(8'h36 + 8'(i));
      tick(2);
    end
    for (int w = 0; w < 3; w++) begin
      p1 = 0;
      window(100, 5);
      chk("t3_pulses_per_window", p1, 1);
      chk("t3_count", fc1, 2 - w);
    end

    // overflow: eight in FIFO, ninth stalls in the hold, tenth is lost
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 9) push_exp(8'h40 + 8'(i));
      strobe_spi(8'h40 + 8'(i));
      tick(2);
    end
    tick(2);
    chk("t4_overflow", ov1, 1);
    chk("t4_drop_count", dc1, 1);
    chk("t4_fifo_count", fc1, 8);
    repeat (9) window(16, 3);
    chk("t4_count_drained", fc1, 0);
    chk("t4_overflow_sticky", ov1, 1);

    // reset during GAP discards queued keys; vblank high at release arms at once
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_exp(8'h50 + 8'(i));
      strobe_spi(8'h50 + 8'(i));
      tick(2);
    end
    tick(2);
    vblank = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (kp1) begin
        found = 1;
        break;
      end
    end
    chk("t5_first_pulse_seen", found, 1);
    #1;
    rst = 1'b1;
    exp1.delete();
    exp4.delete();
    #1;
    chk("t5_key_pressed_in_reset", kp1, 0);
    chk("t5_count_in_reset", fc1, 0);
    chk("t5_overflow_in_reset", ov1, 0);
    tick(2);
    p1 = 0;
    p4 = 0;
    rst = 1'b0;
    tick(20);
    chk("t5_no_pulse1_after_reset", p1, 0);
    chk("t5_no_pulse4_after_reset", p4, 0);
    push_exp(8'h39);
    strobe_spi(8'h39);
    tick(15);
    chk("t5_new_key_pulse", p1, 1);
    chk("t5_count_after_new", fc1, 0);
    vblank = 1'b0;
    tick(3);

    // key filter
    do_reset();
`ifdef KEY_FILTER_EN
    push_exp(8'h2B);
`else
    push_exp(8'h41);
    push_exp(8'h2B);
`endif
    strobe_spi(8'h41);
    tick(2);
    strobe_spi(8'h2B);
    tick(3);
`ifdef KEY_FILTER_EN
    chk("t6_count", fc1, 1);
`else
    chk("t6_count", fc1, 2);
`endif
    window(10, 3);
    window(10, 3);
    chk("t6_overflow", ov1, 0);
    chk("t6_count_drained", fc1, 0);

    tick(5);
    chk("end_queue1_empty", exp1.size(), 0);
    chk("end_queue4_empty", exp4.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
